// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 16x16 unsigned multiplier, one conditional add per cycle over 16 cycles.
// Includes the 16-bit ripple adder it uses as its only add datapath.
module adder (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] o,
  output logic        co
);
  logic [16:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign o[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end
  assign co = w_c[16];
endmodule

module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state;
  logic [15:0] r_m, r_acc_hi, r_acc_lo;
  logic [4:0]  r_cnt;
  logic        r_busy, r_done;
  logic [31:0] r_product;
  logic [15:0] w_sum;
  logic        w_co;
  logic [31:0] w_next;

  adder u_adder (.x(r_acc_hi), .y(r_m), .o(w_sum), .co(w_co));

  // The add carry becomes bit 15 of the shifted high half, so nothing is lost.
  assign w_next = r_acc_lo[0] ? {w_co, w_sum, r_acc_lo[15:1]}
                              : {1'b0, r_acc_hi, r_acc_lo[15:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_m      <= a;
          r_acc_hi <= '0;
          r_acc_lo <= b;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
          r_state  <= RUN;
        end
        RUN: begin
          r_acc_hi <= w_next[31:16];
          r_acc_lo <= w_next[15:0];
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd15) begin
            r_product <= w_next;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized and directed checks against a plain-arithmetic product model.
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done;
  logic [31:0] product;
  int vectors = 0;
  int miscompares = 0;

  shift_add_multiplier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Drives start for one edge, returns at the negedge after the accepting edge.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
  endtask

  // Counts negedges after the accepting edge until done; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({product, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: product=%h busy=%b done=%b want 0/0/0", product, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({product, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: product=%h busy=%b done=%b want 0/0/0", i, product, busy, done);
      end
    end
  endtask

  task automatic test_basic(input logic [15:0] x, input logic [15:0] y, input string name);
    int cyc;
    launch(x, y);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_busy_after_accept: busy=%b want 1", name, busy);
    end
    wait_done(cyc);
    vectors++;
    if (cyc != 16) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d want 16", name, cyc);
    end
    vectors++;
    if (product !== model(x, y)) begin
      miscompares++;
      $display("FAIL %s_product: got %h want %h", name, product, model(x, y));
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_after_done: busy=%b done=%b want 0/0", name, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, gap;
    a = 16'h0000; b = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h1234; b = 16'h5678;
    wait_done(cyc);
    vectors++;
    if (cyc != 16 || product !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_first: latency=%0d product=%h want 16/00000000", cyc, product);
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (done !== 1'b1) begin
        vectors++;
        if (product !== 32'h0) begin
          miscompares++;
          $display("FAIL b2b_hold cycle %0d: product=%h want 00000000", gap, product);
        end
      end
    end while (done !== 1'b1 && gap < 40);
    start = 1'b0;
    vectors++;
    if (gap != 18) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses want 18", gap);
    end
    vectors++;
    if (product !== 32'h06260060) begin
      miscompares++;
      $display("FAIL b2b_product: got %h want 06260060", product);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int cyc, pulses;
    launch(16'd7, 16'd9);
    repeat (5) @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    cyc = 6;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != 16) begin
      miscompares++;
      $display("FAIL ignored_latency: got %0d want 16", cyc);
    end
    vectors++;
    if (product !== 32'h3F) begin
      miscompares++;
      $display("FAIL ignored_product: got %h want 0000003f", product);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      pulses += int'(done);
    end
    vectors++;
    if (pulses != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_second_op: extra done pulses=%0d busy=%b want 0/0", pulses, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    launch(16'hFFFF, 16'h0002);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({product, busy, done} !== {32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: product=%h busy=%b done=%b want 0/0/0", product, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      pulses += int'(done) + int'(busy);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_mid_discard: done/busy seen %0d times want 0", pulses);
    end
    test_basic(16'd2, 16'd3, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    for (int n = 0; n < 25; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (n == 0) y = 16'h8000;
      if (n == 1) x = 16'h0001;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_basic(x, y, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic(16'd3, 16'd5, "basic");
    vectors++;
    if (product !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL basic_const: got %h want 0000000f", product);
    end
    test_basic(16'hFFFF, 16'hFFFF, "max");
    vectors++;
    if (product !== 32'hFFFE0001) begin
      miscompares++;
      $display("FAIL max_const: got %h want fffe0001", product);
    end
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
